// File: rtl/key_scan_reader.sv
// key_scan_reader
// Scans a 4x4 active-low matrix keypad one row at a time. It assembles the
// column samples into full-scan frames, debounces the frame results, and
// presents single-key press events to the CPU as a polled read source.
// The CPU polls key_valid, reads key_code, and acknowledges with rd_en.
// key_code packs the key position as {row[1:0], col[1:0]}.

module key_scan_reader #(
  parameter int SCAN_DIV        = 50000,  // clk cycles per row (min 4)
  parameter int DEBOUNCE_FRAMES = 4       // identical frames to accept (1..15)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  input  logic       rd_en,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_pressed,
  output logic       overrun
);

  // Prescaler geometry.
  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

  // Debounce threshold, held in the same width as the stable counter.
  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_FRAMES);

  // Frame result kinds. MULTI is kept distinct so that a chord is never
  // mistaken for a key or for a release.
  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_KEY   = 2'd1;
  localparam logic [1:0] RES_MULTI = 2'd2;

  // Number of low bits in one row sample, saturated at 2.
  // Only "none", "one" and "more than one" matter.
  function automatic logic [1:0] low_count(input logic [3:0] low);
    logic [2:0] sum;
    sum = {2'b00, low[0]} + {2'b00, low[1]} + {2'b00, low[2]} + {2'b00, low[3]};
    if (sum > 3'd2) begin
      return 2'd2;
    end else begin
      return sum[1:0];
    end
  endfunction

  // Index of the lowest-numbered low column.
  function automatic logic [1:0] low_index(input logic [3:0] low);
    if (low[0]) begin
      return 2'd0;
    end else if (low[1]) begin
      return 2'd1;
    end else if (low[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  // Saturating add of two key counts. The result is capped at 2.
  function automatic logic [1:0] sat_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > 3'd2) begin
      return 2'd2;
    end else begin
      return sum[1:0];
    end
  endfunction

  // Synchroniser and scan state.
  logic [3:0]       col_meta_r;
  logic [3:0]       col_sync_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic [1:0]       row_idx_r;
  logic [3:0]       row_out_r;

  // Frame accumulation and debounce state.
  logic [1:0]       acc_cnt_r;
  logic [3:0]       acc_code_r;
  logic [1:0]       prev_kind_r;
  logic [3:0]       prev_code_r;
  logic [3:0]       stable_cnt_r;

  // Output registers.
  logic             key_valid_r;
  logic [3:0]       key_code_r;
  logic             key_pressed_r;
  logic             overrun_r;

  // Combinational decode.
  logic             tick_s;
  logic             frame_done_s;
  logic [1:0]       row_next_s;
  logic [3:0]       col_low_s;
  logic [1:0]       row_cnt_s;
  logic [1:0]       base_cnt_s;
  logic [3:0]       base_code_s;
  logic [1:0]       frame_cnt_s;
  logic [3:0]       frame_code_s;
  logic [1:0]       res_kind_s;
  logic [3:0]       res_code_s;
  logic             same_s;
  logic [3:0]       stable_next_s;
  logic             accept_s;
  logic             press_acc_s;
  logic             release_acc_s;

  assign tick_s       = (div_cnt_r == DIV_LAST);
  assign frame_done_s = tick_s && (row_idx_r == 2'd3);
  assign row_next_s   = row_idx_r + 2'd1;
  assign col_low_s    = ~col_sync_r;

  // Two-flop synchroniser for the asynchronous column inputs.
  // It idles high, the same as released keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_r <= 4'b1111;
      col_sync_r <= 4'b1111;
    end else begin
      col_meta_r <= col_in;
      col_sync_r <= col_meta_r;
    end
  end

  // Row prescaler: counts 0..SCAN_DIV-1 and wraps.
  // The last count is the scan tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= DIV_ZERO;
    end else if (tick_s) begin
      div_cnt_r <= DIV_ZERO;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

  // Row sequencer: on each tick, move to the next row.
  // The one-hot low row drive changes in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx_r <= 2'd0;
      row_out_r <= 4'b1110;
    end else if (tick_s) begin
      row_idx_r <= row_next_s;
      row_out_r <= ~(4'b0001 << row_next_s);
    end else begin
      row_idx_r <= row_idx_r;
      row_out_r <= row_out_r;
    end
  end

  // Combine the current row sample with the frame so far.
  // Then classify the frame and decide whether the debounce threshold is crossed.
  always_comb begin
    base_cnt_s    = acc_cnt_r;
    base_code_s   = acc_code_r;
    frame_code_s  = acc_code_r;
    res_kind_s    = RES_NONE;
    res_code_s    = 4'd0;
    stable_next_s = stable_cnt_r;
    accept_s      = 1'b0;

    // Row 0 starts a fresh frame, so earlier rows are ignored.
    if (row_idx_r == 2'd0) begin
      base_cnt_s  = 2'd0;
      base_code_s = 4'd0;
    end else begin
      base_cnt_s  = acc_cnt_r;
      base_code_s = acc_code_r;
    end

    row_cnt_s   = low_count(col_low_s);
    frame_cnt_s = sat_add(base_cnt_s, row_cnt_s);

    // The first key found in the frame provides the code.
    if ((base_cnt_s == 2'd0) && (row_cnt_s != 2'd0)) begin
      frame_code_s = {row_idx_r, low_index(col_low_s)};
    end else begin
      frame_code_s = base_code_s;
    end

    case (frame_cnt_s)
      2'd0:    res_kind_s = RES_NONE;
      2'd1:    res_kind_s = RES_KEY;
      default: res_kind_s = RES_MULTI;
    endcase

    // Code is zeroed for NONE and MULTI so results compare on kind alone.
    if (res_kind_s == RES_KEY) begin
      res_code_s = frame_code_s;
    end else begin
      res_code_s = 4'd0;
    end

    same_s = (res_kind_s == prev_kind_r) && (res_code_s == prev_code_r);

    // Acceptance fires only on the step into the threshold, never while saturated.
    if (same_s) begin
      if (stable_cnt_r < DEB_MAX) begin
        stable_next_s = stable_cnt_r + 4'd1;
      end else begin
        stable_next_s = stable_cnt_r;
      end
      accept_s = frame_done_s && (stable_cnt_r == (DEB_MAX - 4'd1));
    end else begin
      stable_next_s = 4'd1;
      accept_s      = frame_done_s && (DEB_MAX == 4'd1);
    end
  end

  assign press_acc_s   = accept_s && (res_kind_s == RES_KEY);
  assign release_acc_s = accept_s && (res_kind_s == RES_NONE);

  // Per-row frame accumulator: running key count and first-key code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 4'd0;
    end else if (tick_s) begin
      acc_cnt_r  <= frame_cnt_s;
      acc_code_r <= frame_code_s;
    end else begin
      acc_cnt_r  <= acc_cnt_r;
      acc_code_r <= acc_code_r;
    end
  end

  // Debounce history: previous frame result and how many frames it has held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_kind_r  <= RES_NONE;
      prev_code_r  <= 4'd0;
      stable_cnt_r <= 4'd0;
    end else if (frame_done_s) begin
      prev_kind_r  <= res_kind_s;
      prev_code_r  <= res_code_s;
      stable_cnt_r <= stable_next_s;
    end else begin
      prev_kind_r  <= prev_kind_r;
      prev_code_r  <= prev_code_r;
      stable_cnt_r <= stable_cnt_r;
    end
  end

  // Event register: a press posts a new code. The press wins over a
  // coincident acknowledge. An unread event that is replaced flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_r <= 1'b0;
      key_code_r  <= 4'd0;
      overrun_r   <= 1'b0;
    end else if (press_acc_s) begin
      key_valid_r <= 1'b1;
      key_code_r  <= res_code_s;
      if (rd_en) begin
        overrun_r <= 1'b0;
      end else if (key_valid_r) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end
    end else if (rd_en) begin
      key_valid_r <= 1'b0;
      key_code_r  <= key_code_r;
      overrun_r   <= 1'b0;
    end else begin
      key_valid_r <= key_valid_r;
      key_code_r  <= key_code_r;
      overrun_r   <= overrun_r;
    end
  end

  // Debounced held-key level: set on a press acceptance, cleared on a release.
  // MULTI acceptance leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_pressed_r <= 1'b0;
    end else if (press_acc_s) begin
      key_pressed_r <= 1'b1;
    end else if (release_acc_s) begin
      key_pressed_r <= 1'b0;
    end else begin
      key_pressed_r <= key_pressed_r;
    end
  end

  assign row_out     = row_out_r;
  assign key_valid   = key_valid_r;
  assign key_code    = key_code_r;
  assign key_pressed = key_pressed_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_key_scan_reader.sv
// Directed testbench for key_scan_reader with a behavioural 4x4 keypad model.
// It runs with SCAN_DIV=4 and DEBOUNCE_FRAMES=2, so one frame is 16 clk cycles.

module tb_key_scan_reader;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic        rd_en;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic        overrun;

  logic [15:0] keys;        // keys[r*4+c] = 1 means the key is held
  int          cyc;         // posedges since reset release
  int          n_compared;
  int          n_mismatched;
  int          bad;
  logic [3:0]  one_hot;
  logic [3:0]  exp_row;

  key_scan_reader #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .col_in      (col_in),
    .row_out     (row_out),
    .rd_en       (rd_en),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_pressed (key_pressed),
    .overrun     (overrun)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a held key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
      end
    end
  end

  // Cycle counter that tracks the scan phase from reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_rd;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic wait_valid(input int bound);
    for (int i = 0; i < bound && !key_valid; i++) @(negedge clk);
  endtask

  task automatic wait_pressed(input logic lvl, input int bound);
    for (int i = 0; i < bound && (key_pressed !== lvl); i++) @(negedge clk);
  endtask

  task automatic align_phase(input int ph);
    for (int i = 0; i < 16 && (cyc % 16) != ph; i++) @(negedge clk);
  endtask

  // Watchdog: every wait is bounded, so this should never trigger.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    keys  = 16'h0000;
    rd_en = 1'b0;
    rst_n = 1'b0;
    one_hot = 4'b0001;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_row",     32'(row_out),     32'hE);
    check_eq("rst_valid",   32'(key_valid),   32'h0);
    check_eq("rst_code",    32'(key_code),    32'h0);
    check_eq("rst_pressed", 32'(key_pressed), 32'h0);
    check_eq("rst_overrun", 32'(overrun),     32'h0);

    // Idle scan: each row is held for 4 clk, starting at row 0
    rst_n = 1'b1;
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp_row = ~(one_hot << ((i / 4) % 4));
      check_eq("idle_row", 32'(row_out), 32'(exp_row));
      if (key_valid || key_pressed || overrun || key_code != 4'h0) bad++;
    end
    check_eq("idle_outputs", 32'(bad), 32'd0);

    // Press key 9 (row 2, column 1)
    keys[9] = 1'b1;
    repeat (16) @(negedge clk);
    check_eq("press9_not_early", 32'(key_valid), 32'h0);
    wait_valid(34);
    check_eq("press9_valid",   32'(key_valid),   32'h1);
    check_eq("press9_code",    32'(key_code),    32'h9);
    check_eq("press9_pressed", 32'(key_pressed), 32'h1);
    check_eq("press9_overrun", 32'(overrun),     32'h0);

    // Release: the level drops and the code is kept
    keys = 16'h0000;
    repeat (16) @(negedge clk);
    check_eq("rel9_not_early", 32'(key_pressed), 32'h1);
    wait_pressed(1'b0, 34);
    check_eq("rel9_pressed", 32'(key_pressed), 32'h0);
    check_eq("rel9_code",    32'(key_code),    32'h9);
    check_eq("rel9_valid",   32'(key_valid),   32'h1);

    // Acknowledge, then send a second unrelated acknowledge
    pulse_rd();
    check_eq("ack_valid",   32'(key_valid), 32'h0);
    check_eq("ack_overrun", 32'(overrun),   32'h0);
    pulse_rd();
    check_eq("ack2_valid", 32'(key_valid),   32'h0);
    check_eq("ack2_code",  32'(key_code),    32'h9);
    check_eq("ack2_press", 32'(key_pressed), 32'h0);

    // Bounce on key 0. The phase is chosen so that the row-0 samples see
    // released, pressed, released. Then the key is held.
    align_phase(12);
    bad = 0;
    for (int i = 0; i < 48; i++) begin
      keys[0] = ((i / 5) % 2) == 0;
      @(negedge clk);
      if (key_valid) bad++;
    end
    keys[0] = 1'b1;
    check_eq("bounce_quiet", 32'(bad), 32'd0);
    wait_valid(60);
    check_eq("bounce_valid", 32'(key_valid), 32'h1);
    check_eq("bounce_code",  32'(key_code),  32'h0);
    pulse_rd();
    bad = 0;
    repeat (48) begin
      @(negedge clk);
      if (key_valid) bad++;
    end
    check_eq("bounce_single", 32'(bad), 32'd0);
    keys = 16'h0000;
    wait_pressed(1'b0, 60);
    check_eq("bounce_rel", 32'(key_pressed), 32'h0);

    // Overrun: press 3, release, then press F without reading
    keys[3] = 1'b1;
    wait_valid(60);
    check_eq("ovr_code3", 32'(key_code), 32'h3);
    keys = 16'h0000;
    wait_pressed(1'b0, 60);
    keys[15] = 1'b1;
    wait_pressed(1'b1, 60);
    check_eq("ovr_codeF",   32'(key_code),  32'hF);
    check_eq("ovr_valid",   32'(key_valid), 32'h1);
    check_eq("ovr_overrun", 32'(overrun),   32'h1);
    pulse_rd();
    check_eq("ovr_ack_valid",   32'(key_valid), 32'h0);
    check_eq("ovr_ack_overrun", 32'(overrun),   32'h0);

    // Press wins over a coincident acknowledge. An event is left pending
    // first, so the accept cycle also exercises the overrun path.
    keys = 16'h0000;
    wait_pressed(1'b0, 60);
    keys[3] = 1'b1;
    wait_valid(60);
    check_eq("pend3_valid", 32'(key_valid), 32'h1);
    keys = 16'h0000;
    wait_pressed(1'b0, 60);
    align_phase(0);
    keys[15] = 1'b1;
    repeat (31) @(negedge clk);
    pulse_rd();
    check_eq("coinc_valid",   32'(key_valid), 32'h1);
    check_eq("coinc_code",    32'(key_code),  32'hF);
    check_eq("coinc_overrun", 32'(overrun),   32'h0);

    // MULTI: key 5 is held, then key 6 joins. No event, and the level is kept.
    keys = 16'h0000;
    wait_pressed(1'b0, 60);
    pulse_rd();
    keys[5] = 1'b1;
    wait_valid(60);
    check_eq("multi_code5", 32'(key_code), 32'h5);
    keys[6] = 1'b1;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (!key_valid || !key_pressed || key_code != 4'h5 || overrun) bad++;
    end
    check_eq("multi_hold", 32'(bad), 32'd0);

    // Asynchronous reset in the middle of a frame
    align_phase(6);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_row",     32'(row_out),     32'hE);
    check_eq("mrst_valid",   32'(key_valid),   32'h0);
    check_eq("mrst_code",    32'(key_code),    32'h0);
    check_eq("mrst_pressed", 32'(key_pressed), 32'h0);
    check_eq("mrst_overrun", 32'(overrun),     32'h0);
    keys = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("mrst_restart_row0", 32'(row_out), 32'hE);
    repeat (3) @(negedge clk);
    check_eq("mrst_restart_row1", 32'(row_out), 32'hD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/key_scan_reader.md
Name: key_scan_reader

Overview:
- Input-side counterpart of the 7-segment display scanner: scans a 4x4 matrix keypad by driving rows and reading columns.
- Debounces the keypad and presents single-key press events to the miniCPU as a memory-mapped read source.
- Sits in the top-level next to the display path and runs on the main CPU clock.
- The CPU polls key_valid, reads key_code, and pulses rd_en to acknowledge.

Parameters:
- SCAN_DIV, 50000: clk cycles each row stays driven before its columns are sampled (min 4).
- DEBOUNCE_FRAMES, 4: consecutive identical full-scan frames required to accept a press or release (min 1, max 15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- col_in  input  4  keypad columns, active-low, externally pulled up, asynchronous to clk
- row_out  output  4  keypad rows, one-hot active-low drive
- rd_en  input  1  CPU read-acknowledge strobe, one clk wide
- key_valid  output  1  unread press event pending
- key_code  output  4  code of last accepted press = {row[1:0], col[1:0]}
- key_pressed  output  1  debounced level: a key is currently held
- overrun  output  1  a press event arrived while the previous one was unread

Behaviour:
- Reset (async, rst_n=0): row_out=4'b1110, key_valid=0, key_code=0, key_pressed=0, overrun=0. Prescaler, row index, frame accumulators and stable counter are cleared. Synchroniser flops are set to 4'b1111.
- Synchroniser: col_in passes through 2 flops; all logic uses the synchronised value.
- Prescaler counts 0..SCAN_DIV-1 and wraps. A scan tick occurs on the count==SCAN_DIV-1 cycle.
- On a tick:
  - Sample the synchronised columns for current row r, then advance r (3 wraps to 0).
  - row_out = ~(1<<r), updated in the same cycle.
- Frame accumulation over rows 0..3:
  - Count low column bits.
  - Record code = {r, lowest-index low column}.
- Frame result, at the row-3 tick:
  - NONE if zero keys are low.
  - KEY(code) if exactly one key is low.
  - MULTI if more than one key is low. MULTI is treated as a distinct result and never produces an event.
- Debounce:
  - If the frame result equals the previous frame result, stable_cnt increments, saturating at DEBOUNCE_FRAMES.
  - Otherwise stable_cnt=1 and the result is stored.
  - Acceptance occurs in the cycle stable_cnt becomes DEBOUNCE_FRAMES (a transition, not while already saturated).
- Press accept: triggered by KEY(c) acceptance.
  - key_code<=c, key_pressed<=1, key_valid<=1.
  - If key_valid was 1 and rd_en is 0 in that cycle, overrun<=1.
  - A code change without an intervening NONE acceptance (for example a slide from one key to another) also produces an event.
- Release accept: triggered by NONE acceptance.
  - key_pressed<=0. key_code holds its value.
- MULTI acceptance: no change to any output.
- Acknowledge: rd_en=1 gives key_valid<=0 and overrun<=0 next edge.
- Simultaneous rd_en and press accept in the same cycle: the press wins. key_valid stays 1 with the new code and overrun stays 0.
- Latency: a clean press stable from before a frame starts produces key_valid DEBOUNCE_FRAMES frames later, plus up to 1 partial frame and 2 sync cycles. One frame = 4*SCAN_DIV cycles.
- Outputs are all registered; there is no combinational path from col_in or rd_en to outputs.
- Reset mid-scan or mid-debounce discards any partial frame. Scanning restarts at row 0 in the first cycle after rst_n deasserts.

Test Plan:
- Set SCAN_DIV=4, DEBOUNCE_FRAMES=2, frame=16 cycles.
  - Reset, then idle: row_out cycles 1110->1101->1011->0111 every 4 clk. Outputs stay 0.
- Hold key row2/col1 (col_in[1]=0 while row_out=1011).
  - key_valid rises within 2 frames plus 18 cycles; key_code=4'h9, key_pressed=1.
  - Release: key_pressed=0 after 2 frames; key_code stays 9.
- Pulse rd_en once after a press: key_valid=0 next edge. A second unrelated rd_en causes no change.
- Bounce: toggle col_in[0] on row 0 every 5 cycles for 3 frames, then hold low.
  - No event during bouncing; exactly one event with key_code=0 after hold.
- Overrun: press key 3, release, press key 0xF without rd_en.
  - key_code=F, key_valid=1, overrun=1. rd_en clears both.
  - Press key 0xF again with rd_en coincident on the accept cycle: key_valid=1, overrun=0.
- MULTI and reset:
  - Hold keys 5 and 6 together: no event and key_pressed unchanged.
  - Assert rst_n=0 mid-frame: all outputs 0 immediately and row_out=1110.
